// File: rtl/uart_pkg.sv
// Shared UART definitions for the RX and TX bridges.
// Holds the receiver FSM state type, the default packet-format constants
// and a small width helper used to size counters.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int unsigned UART_CLOCKS_PER_PULSE = 4;
    localparam int unsigned UART_BITS_PER_WORD    = 8;
    localparam int unsigned UART_PACKET_SIZE      = 13;

    // Bits needed to hold 0..n-1, never less than 1.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_word.sv
// UART word receiver: 2-flop synchroniser, bit-timing counters and FSM.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   rx          raw serial input (idles high)
//   word        received data bits, LSB = first bit on the line
//   word_valid  1-cycle pulse, word is complete and all end bits were high
//   err         1-cycle pulse, at least one end bit was sampled low
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = UART_CLOCKS_PER_PULSE,
    parameter int unsigned BITS_PER_WORD    = UART_BITS_PER_WORD,
    parameter int unsigned PACKET_SIZE      = UART_PACKET_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] word,
    output logic                     word_valid,
    output logic                     err
);

    localparam int unsigned NUM_END = PACKET_SIZE - BITS_PER_WORD - 1;
    localparam int unsigned CNT_W   = width_of(CLOCKS_PER_PULSE);
    localparam int unsigned BIT_W   = width_of((BITS_PER_WORD > NUM_END) ? BITS_PER_WORD : NUM_END);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [BIT_W-1:0] LAST_END  = BIT_W'(NUM_END - 1);

    logic                     rx_meta, rx_s;
    uart_state_t              state, state_n;
    logic [CNT_W-1:0]         cnt, cnt_n;
    logic [BIT_W-1:0]         bit_cnt, bit_cnt_n;
    logic [BITS_PER_WORD-1:0] shreg, shreg_n;
    logic                     err_q, err_n;
    logic                     expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            err_q   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        err_n      = err_q;
        word_valid = 1'b0;
        err        = 1'b0;
        expire     = (cnt == '0);

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_n   = HALF_LOAD;
                    state_n = START;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s) begin
                    state_n = IDLE;
                end else begin
                    cnt_n     = FULL_LOAD;
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    // LSB arrives first: shift right, new bit enters at the top.
                    shreg_n                    = shreg >> 1;
                    shreg_n[BITS_PER_WORD-1]   = rx_s;
                    cnt_n                      = FULL_LOAD;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
                        err_n     = 1'b0;
                        state_n   = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    cnt_n = FULL_LOAD;
                    if (bit_cnt == LAST_END) begin
                        // Leave mid last end bit so a zero-gap start edge is caught.
                        bit_cnt_n = '0;
                        state_n   = IDLE;
                        if (err_q || !rx_s) begin
                            err = 1'b1;
                        end else begin
                            word_valid = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        if (!rx_s) begin
                            err_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign word = shreg;

endmodule

// File: rtl/uart_rx_to_axi_stream.sv
// UART receiver feeding an AXI-Stream master.
// Collects NUM_WORDS UART words into one W_OUT-bit beat, word 0 in the low slice.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   rx          UART serial input (idles high)
//   m_data      AXIS data
//   m_valid     AXIS valid
//   m_ready     AXIS ready
//   frame_err   1-cycle pulse, an end bit was sampled low (partial beat dropped)
//   overflow    1-cycle pulse, completed beat dropped because output still full
module uart_rx_to_axi_stream
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = UART_CLOCKS_PER_PULSE,
    parameter int unsigned BITS_PER_WORD    = UART_BITS_PER_WORD,
    parameter int unsigned PACKET_SIZE      = UART_PACKET_SIZE,
    parameter int unsigned W_OUT            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [W_OUT-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             frame_err,
    output logic             overflow
);

    localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int unsigned IDX_W     = width_of(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [BITS_PER_WORD-1:0] word;
    logic                     word_valid;
    logic                     word_err;
    logic [IDX_W-1:0]         word_idx;
    logic [W_OUT-1:0]         beat_q;
    logic [W_OUT-1:0]         beat_merged;
    logic                     beat_done;

    uart_rx_word #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD),
        .PACKET_SIZE     (PACKET_SIZE)
    ) u_word (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .word      (word),
        .word_valid(word_valid),
        .err       (word_err)
    );

    // Current word merged into its slice, so a completing beat can load m_data directly.
    always_comb begin
        beat_merged = beat_q;
        for (int unsigned k = 0; k < NUM_WORDS; k++) begin
            if (word_idx == IDX_W'(k)) begin
                beat_merged[k*BITS_PER_WORD +: BITS_PER_WORD] = word;
            end
        end
        beat_done = word_valid && (word_idx == LAST_IDX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx  <= '0;
            beat_q    <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= word_err;
            overflow  <= 1'b0;

            if (word_err) begin
                word_idx <= '0;
            end else if (word_valid) begin
                beat_q   <= beat_merged;
                word_idx <= beat_done ? '0 : word_idx + 1'b1;
            end

            if (beat_done && (!m_valid || m_ready)) begin
                m_data  <= beat_merged;
                m_valid <= 1'b1;
            end else begin
                if (beat_done) begin
                    overflow <= 1'b1;
                end
                if (m_valid && m_ready) begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_to_axi_stream.sv
// Directed self-checking bench for uart_rx_to_axi_stream (default parameters:
// 4 clocks/bit, 8 data bits, 13-bit packet, 16-bit beat).
module tb_uart_rx_to_axi_stream;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        frame_err;
    logic        overflow;

    int unsigned n_eval = 0;
    int unsigned n_fail = 0;

    // Observation counters, updated on the falling edge.
    int unsigned beats = 0, vcycles = 0, ferrs = 0, ovfs = 0, stab_viol = 0;
    logic [15:0] last_beat = '0;
    logic [15:0] prev_data = '0;
    logic        prev_hold = 1'b0;

    int unsigned b0, v0, f0, o0;

    always #5 clk = ~clk;

    uart_rx_to_axi_stream #(
        .CLOCKS_PER_PULSE(4),
        .BITS_PER_WORD   (8),
        .PACKET_SIZE     (13),
        .W_OUT           (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .frame_err(frame_err),
        .overflow (overflow)
    );

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            beats++;
            last_beat = m_data;
        end
        if (m_valid)   vcycles++;
        if (frame_err) ferrs++;
        if (overflow)  ovfs++;
        if (prev_hold && (m_data !== prev_data)) stab_viol++;
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_eval++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int bad_end);
        rx = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(4);
        end
        for (int i = 0; i < 4; i++) begin
            rx = (i == bad_end) ? 1'b0 : 1'b1;
            tick(4);
        end
        rx = 1'b1;
    endtask

    task automatic snap();
        b0 = beats;
        v0 = vcycles;
        f0 = ferrs;
        o0 = ovfs;
    endtask

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        m_ready = 1'b0;
        tick(3);

        // Reset state
        sample();
        check("rst_m_data", 32'(m_data), 32'h0);
        check("rst_m_valid", 32'(m_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_state", 32'(dut.u_word.state), 32'(IDLE));
        tick(1);
        rst = 1'b0;
        tick(5);

        // 1: A5, 3C with ready high -> single-cycle beat 3CA5
        m_ready = 1'b1;
        snap();
        send_frame(8'hA5, -1);
        send_frame(8'h3C, -1);
        tick(10);
        sample();
        check("t1_beats", 32'(beats - b0), 32'd1);
        check("t1_data", 32'(last_beat), 32'h3CA5);
        check("t1_valid_cycles", 32'(vcycles - v0), 32'd1);
        check("t1_frame_err", 32'(ferrs - f0), 32'd0);

        // 2: 11, 22 held under backpressure for 50 cycles
        tick(1);
        m_ready = 1'b0;
        snap();
        send_frame(8'h11, -1);
        send_frame(8'h22, -1);
        tick(10);
        sample();
        check("t2_valid_early", 32'(m_valid), 32'h1);
        check("t2_data_early", 32'(m_data), 32'h2211);
        tick(50);
        sample();
        check("t2_valid_late", 32'(m_valid), 32'h1);
        check("t2_data_late", 32'(m_data), 32'h2211);
        tick(1);
        m_ready = 1'b1;
        tick(2);
        sample();
        check("t2_beats", 32'(beats - b0), 32'd1);
        check("t2_beat_data", 32'(last_beat), 32'h2211);
        check("t2_valid_cleared", 32'(m_valid), 32'h0);
        check("t2_stable", 32'(stab_viol), 32'd0);

        // 3: one-cycle glitch on rx is a false start
        tick(1);
        snap();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        sample();
        check("t3_state_idle", 32'(dut.u_word.state), 32'(IDLE));
        check("t3_beats", 32'(beats - b0), 32'd0);
        check("t3_frame_err", 32'(ferrs - f0), 32'd0);
        check("t3_valid", 32'(m_valid), 32'h0);

        // 4: bad 2nd end bit on first word, then 55, AA
        tick(1);
        snap();
        send_frame(8'h77, 1);
        send_frame(8'h55, -1);
        send_frame(8'hAA, -1);
        tick(10);
        sample();
        check("t4_frame_err", 32'(ferrs - f0), 32'd1);
        check("t4_beats", 32'(beats - b0), 32'd1);
        check("t4_data", 32'(last_beat), 32'hAA55);

        // 5: two beats with ready low -> first held, second dropped
        tick(1);
        m_ready = 1'b0;
        snap();
        send_frame(8'h12, -1);
        send_frame(8'h34, -1);
        send_frame(8'h56, -1);
        send_frame(8'h78, -1);
        tick(10);
        sample();
        check("t5_valid", 32'(m_valid), 32'h1);
        check("t5_data_held", 32'(m_data), 32'h3412);
        check("t5_overflow", 32'(ovfs - o0), 32'd1);
        check("t5_stable", 32'(stab_viol), 32'd0);
        tick(1);
        m_ready = 1'b1;
        tick(3);
        sample();
        check("t5_beats", 32'(beats - b0), 32'd1);
        check("t5_beat_data", 32'(last_beat), 32'h3412);
        check("t5_valid_cleared", 32'(m_valid), 32'h0);

        // 6: reset mid DATA of word 1 discards word 0
        tick(1);
        send_frame(8'hEE, -1);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        sample();
        check("t6_rst_m_data", 32'(m_data), 32'h0);
        check("t6_rst_m_valid", 32'(m_valid), 32'h0);
        check("t6_rst_frame_err", 32'(frame_err), 32'h0);
        check("t6_rst_overflow", 32'(overflow), 32'h0);
        check("t6_rst_state", 32'(dut.u_word.state), 32'(IDLE));
        tick(3);
        rst = 1'b0;
        tick(5);
        snap();
        send_frame(8'h01, -1);
        send_frame(8'h02, -1);
        tick(10);
        sample();
        check("t6_beats", 32'(beats - b0), 32'd1);
        check("t6_data", 32'(last_beat), 32'h0201);
        check("t6_frame_err", 32'(ferrs - f0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
